// File: rtl/param_shifter.sv
// rtl/param_shifter.sv - WIDTH-bit load/shift register with multi-cycle shift engine
module param_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             shift_out
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] M_LOGICAL = 2'b00;
    localparam logic [1:0] M_ARITH   = 2'b01;
    localparam logic [1:0] M_ROTATE  = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             so_q, so_d;
    logic             fill_right, fill_left;

    // Bit entering the register on a single-bit shift, one per direction
    always_comb begin
        fill_right = serial_in;
        fill_left  = serial_in;
        case (mode_q)
            M_LOGICAL: begin
                fill_right = 1'b0;
                fill_left  = 1'b0;
            end
            M_ARITH: begin
                fill_right = reg_q[WIDTH-1];
                fill_left  = 1'b0;
            end
            M_ROTATE: begin
                fill_right = reg_q[0];
                fill_left  = reg_q[WIDTH-1];
            end
            default: begin
                fill_right = serial_in;
                fill_left  = serial_in;
            end
        endcase
    end

    // Next-state: load beats start/shift; a shift request with zero count only pulses done
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        so_d    = so_q;
        if (!load_n) begin
            reg_d   = load_val;
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (amount != '0) begin
                            dir_d   = dir;
                            mode_d  = mode;
                            cnt_d   = amount;
                            busy_d  = 1'b1;
                            state_d = S_SHIFT;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (dir_q) begin
                        reg_d = {reg_q[WIDTH-2:0], fill_left};
                        so_d  = reg_q[WIDTH-1];
                    end else begin
                        reg_d = {fill_right, reg_q[WIDTH-1:1]};
                        so_d  = reg_q[0];
                    end
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    // State and registered outputs; synchronous active-low reset overrides everything
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            so_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            so_q    <= so_d;
        end
    end

    assign q         = reg_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign shift_out = so_q;

endmodule

// File: tb/tb_param_shifter.sv
// tb/tb_param_shifter.sv - scoreboard bench for param_shifter
module tb_param_shifter;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         load_n = 1'b1;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic [3:0]   amount = '0;
    logic         dir = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         serial_in = 1'b0;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         shift_out;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];
    bit         ser[0:15];
    bit         model_so = 1'b0;

    param_shifter #(.WIDTH(W), .CNT_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .load_n    (load_n),
        .load_val  (load_val),
        .start     (start),
        .amount    (amount),
        .dir       (dir),
        .mode      (mode),
        .serial_in (serial_in),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .shift_out (shift_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: the bits leaving the register form a stream; the first W are the
    // original bits (exit order), the rest are the fill bits. The result after n
    // shifts is the window starting at position n.
    task automatic model(input logic [W-1:0] v, input int n, input bit d, input bit [1:0] m,
                         output logic [W-1:0] qe, output bit so);
        bit s[0:W+15];
        for (int i = 0; i < W; i++) s[i] = d ? v[W-1-i] : v[i];
        for (int j = 0; j < n; j++) begin
            case (m)
                2'b00:   s[W+j] = 1'b0;
                2'b01:   s[W+j] = d ? 1'b0 : v[W-1];
                2'b10:   s[W+j] = s[j];
                default: s[W+j] = ser[j];
            endcase
        end
        for (int b = 0; b < W; b++) begin
            if (d) qe[W-1-b] = s[n+b];
            else   qe[b]     = s[n+b];
        end
        so = (n > 0) ? s[n-1] : model_so;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done q=%0h", q);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                checks++;
                if ({q, shift_out} !== e) begin
                    errors++;
                    $display("FAIL done_result actual q=%0h so=%0b expected q=%0h so=%0b",
                             q, shift_out, e[8:1], e[0]);
                end
            end
        end
    end

    task automatic do_load(input logic [W-1:0] v);
        load_n = 1'b0;
        load_val = v;
        tick();
        load_n = 1'b1;
        load_val = W'($urandom);
    endtask

    task automatic do_op(input string name, input logic [W-1:0] v, input int n,
                         input bit d, input bit [1:0] m, input logic [15:0] pat, input bit use_pat);
        logic [W-1:0] qe;
        bit           so;
        int           cyc;
        for (int i = 0; i < 16; i++) ser[i] = use_pat ? pat[15-i] : 1'($urandom);
        do_load(v);
        model(v, n, d, m, qe, so);
        model_so = so;
        sb.push_back({qe, so});
        start = 1'b1; amount = 4'(n); dir = d; mode = m;
        tick();
        start = 1'b0;
        amount = 4'($urandom); dir = 1'($urandom); mode = 2'($urandom);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            serial_in = ser[cyc];
            cyc++;
            tick();
        end
        check({name, "_busy_cycles"}, 32'(cyc), 32'(n));
        tick();
        check({name, "_done_seen"}, 32'(sb.size()), 32'd0);
        while (sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        // reset with random inputs and an active load
        load_n = 1'b0; load_val = 8'hEE; start = 1'b1; amount = 4'd3;
        dir = 1'($urandom); mode = 2'($urandom); serial_in = 1'($urandom);
        reset = 1'b0;
        tick();
        check("reset_q", 32'(q), 32'h00);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_so", 32'(shift_out), 0);
        reset = 1'b1; load_n = 1'b1; start = 1'b0;
        tick();

        do_op("asr3", 8'hA5, 3, 1'b0, 2'b01, 16'h0, 1'b0);
        check("asr3_q", 32'(q), 32'hF4);
        check("asr3_so", 32'(shift_out), 1);
        do_op("lsr3", 8'hA5, 3, 1'b0, 2'b00, 16'h0, 1'b0);
        check("lsr3_q", 32'(q), 32'h14);
        do_op("rol4", 8'h3C, 4, 1'b1, 2'b10, 16'h0, 1'b0);
        check("rol4_q", 32'(q), 32'hC3);
        do_op("lsr9", 8'hFF, 9, 1'b0, 2'b00, 16'h0, 1'b0);
        check("lsr9_q", 32'(q), 32'h00);
        do_op("ror8", 8'h81, 8, 1'b0, 2'b10, 16'h0, 1'b0);
        check("ror8_q", 32'(q), 32'h81);
        do_op("ser8", 8'h00, 8, 1'b1, 2'b11, 16'hB200, 1'b1);
        check("ser8_q", 32'(q), 32'hB2);
        do_op("zero", 8'h5A, 0, 1'b1, 2'b00, 16'h0, 1'b0);
        check("zero_q", 32'(q), 32'h5A);
        do_op("asr15", 8'h80, 15, 1'b0, 2'b01, 16'h0, 1'b0);
        check("asr15_q", 32'(q), 32'hFF);

        // abort: second start ignored, load mid-shift, no done ever
        do_load(8'h01);
        start = 1'b1; amount = 4'd5; dir = 1'b1; mode = 2'b00;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_mid_q", 32'(q), 32'h04);
        load_n = 1'b0; load_val = 8'h55;
        tick();
        load_n = 1'b1;
        check("abort_q", 32'(q), 32'h55);
        check("abort_busy", 32'(busy), 0);
        for (int i = 0; i < 8; i++) tick();
        check("abort_q_hold", 32'(q), 32'h55);

        // reset during a 6-shift operation
        do_load(8'hC7);
        start = 1'b1; amount = 4'd6; dir = 1'b0; mode = 2'b10;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        check("midrst_q", 32'(q), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_so", 32'(shift_out), 0);
        reset = 1'b1;
        model_so = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // randomized requests
        for (int t = 0; t < 60; t++) begin
            logic [W-1:0] v;
            logic [W-1:0] qe;
            bit           so;
            int           n;
            bit           d;
            bit [1:0]     m;
            v = W'($urandom);
            n = int'($urandom_range(0, 15));
            d = 1'($urandom);
            m = 2'($urandom);
            do_op("rand", v, n, d, m, 16'h0, 1'b0);
            model(v, n, d, m, qe, so);
            check("rand_q_idle", 32'(q), 32'(qe));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
